// File: rtl/pipe_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin pipeline arbiter family.
// Holds the arbiter state encoding and the source-id width helper.
package pipe_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Source id width; a single requester still needs a 1-bit id.
  function automatic int src_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Requester-side and pipeline-side handshake bundle of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface pipe_rr_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 4
);
  import pipe_rr_arbiter_pkg::*;

  localparam int SRC_W = src_width(N_SRC);

  logic [N_SRC-1:0]       in_valid;
  logic [N_SRC*WIDTH-1:0] in_data;
  logic [N_SRC-1:0]       in_last;
  logic [N_SRC-1:0]       in_allowin;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_last;
  logic                   out_allow;

  modport slave (
    input  in_valid, in_data, in_last, out_allow,
    output in_allowin, out_valid, out_data, out_src, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_allow,
    input  in_allowin, out_valid, out_data, out_src, out_last
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr,
// wrapping from N-1 to 0. Reusable by any round-robin arbiter.
module rr_pick
  import pipe_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  int p;
  int d;
  int best;

  // Each requester's distance from ptr along the rotation; smallest wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    p           = int'(ptr);
    d           = 0;
    best        = N;
    for (int i = 0; i < N; i++) begin
      d = (i >= p) ? (i - p) : (i + N - p);
      if (req[i] && (d < best)) begin
        best        = d;
        grant       = W'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter acting as stage 0 of a valid/allowin pipeline,
// with packet lock so multi-beat packets keep the grant until their last beat.
module pipe_rr_arbiter
  import pipe_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_rr_arbiter_if.slave  bus
);

  localparam int SRC_W = src_width(N_SRC);

  arb_state_t       state_reg, state_next;
  logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [SRC_W-1:0] lock_id_reg, lock_id_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SRC_W-1:0] out_src_reg;
  logic             out_last_reg;

  logic [SRC_W-1:0] pick_grant, grant;
  logic             pick_valid, grant_valid;
  logic             stage_allowin, xfer;
  logic [N_SRC-1:0] allowin;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  rr_pick #(.N(N_SRC), .W(SRC_W)) u_pick (
    .req         (bus.in_valid),
    .ptr         (rr_ptr_reg),
    .grant       (pick_grant),
    .grant_valid (pick_valid)
  );

  assign stage_allowin = !out_valid_reg || bus.out_allow;

  // A locked packet owns the grant even while its requester has a gap.
  assign grant       = (state_reg == ARB_LOCKED) ? lock_id_reg : pick_grant;
  assign grant_valid = (state_reg == ARB_LOCKED) || pick_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_allow
      assign allowin[gi] = stage_allowin && grant_valid && (grant == SRC_W'(gi));
    end
  endgenerate

  assign bus.in_allowin = allowin;
  assign xfer           = |(bus.in_valid & allowin);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
        sel_last = bus.in_last[i];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    lock_id_next = lock_id_reg;
    if (xfer) begin
      if (sel_last) begin
        state_next  = ARB_IDLE;
        rr_ptr_next = (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + SRC_W'(1);
      end else begin
        state_next   = ARB_LOCKED;
        lock_id_next = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      rr_ptr_reg  <= '0;
      lock_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      lock_id_reg <= lock_id_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else if (stage_allowin) begin
      out_valid_reg <= xfer;
      if (xfer) begin
        out_data_reg <= sel_data;
        out_src_reg  <= grant;
        out_last_reg <= sel_last;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter: directed per-cycle vector table plus a
// randomized run checked by per-source scoreboard queues.
module tb_pipe_rr_arbiter;
  import pipe_rr_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_rr_arbiter_if #(.N_SRC(N), .WIDTH(W)) bus ();

  pipe_rr_arbiter #(.N_SRC(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       allow;
    logic [3:0] exp_allowin;
    logic       exp_ov;
    logic [1:0] exp_src;
    logic       exp_olast;
  } vec_t;

  vec_t vecs [27];

  task automatic setv(input int i, input logic [3:0] v, input logic [3:0] l, input logic a,
                      input logic [3:0] ea, input logic eov, input logic [1:0] es, input logic el);
    vecs[i].valid = v; vecs[i].last = l; vecs[i].allow = a;
    vecs[i].exp_allowin = ea; vecs[i].exp_ov = eov; vecs[i].exp_src = es; vecs[i].exp_olast = el;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_allow = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random-phase requester state and scoreboard
  logic       pend [N];
  logic       open_pkt [N];
  logic       acc [N];
  logic       cur_last [N];
  logic [3:0] cur_data [N];
  logic [3:0] seq [N];
  logic [4:0] sbq [N][$];
  logic [1:0] owner;
  logic       owner_active;

  task automatic rand_cycle(input bit draining);
    logic [4:0] exp_beat;
    bit want;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!(pend[i] && !acc[i])) begin
        if (acc[i]) open_pkt[i] = !cur_last[i];
        pend[i] = 1'b0;
        want = draining ? open_pkt[i] : ($urandom_range(0, 99) < 55);
        if (want) begin
          pend[i]     = 1'b1;
          cur_data[i] = seq[i];
          seq[i]      = seq[i] + 4'd1;
          cur_last[i] = draining ? 1'b1 : ($urandom_range(0, 2) != 0);
          sbq[i].push_back({cur_data[i], cur_last[i]});
        end
      end
      bus.in_valid[i]      = pend[i];
      bus.in_last[i]       = cur_last[i];
      bus.in_data[i*W +: W] = cur_data[i];
    end
    bus.out_allow = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
    @(negedge clk);
    chk("allowin_onehot", 32'($countones(bus.in_allowin) <= 1), 32'd1);
    for (int i = 0; i < N; i++) acc[i] = bus.in_valid[i] && bus.in_allowin[i];
    if (bus.out_valid && bus.out_allow) begin
      $display("beat src=%0d data=%h last=%0d", bus.out_src, bus.out_data, bus.out_last);
      if (sbq[bus.out_src].size() == 0) begin
        chk("sb_unexpected_beat", {bus.out_data, bus.out_last}, 32'h1ff);
      end else begin
        exp_beat = sbq[bus.out_src].pop_front();
        chk("sb_beat", {bus.out_data, bus.out_last}, exp_beat);
      end
      if (owner_active) chk("no_interleave", bus.out_src, owner);
      owner        = bus.out_src;
      owner_active = !bus.out_last;
    end
  endtask

  function automatic bit sb_idle();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (sbq[i].size() != 0 || pend[i]) r = 1'b0;
    return r;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.in_data = 16'hDCBA;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_allowin", bus.in_allowin, 4'b0000);

    // Reset mid-packet: move ptr to 3, lock src3, then pulse rst between edges
    @(posedge clk); #1;
    bus.in_valid = 4'b0100; bus.in_last = 4'b0100;
    @(negedge clk);
    chk("t1_grant_src2", bus.in_allowin, 4'b0100);
    @(posedge clk); #1;
    bus.in_valid = 4'b1000; bus.in_last = 4'b0000;
    @(negedge clk);
    chk("t1_grant_src3", bus.in_allowin, 4'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_locked_ov", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    #1;
    chk("t1_async_ov", bus.out_valid, 0);
    chk("t1_async_src", bus.out_src, 0);
    chk("t1_async_allowin", bus.in_allowin, 4'b0000);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 4'b1111; bus.in_last = 4'b1111;
    @(negedge clk);
    chk("t1_first_grant_src0", bus.in_allowin, 4'b0001);
    $display("reset mid-packet: allowin=%b", bus.in_allowin);
    @(posedge clk); #1;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("t1_out_src0", bus.out_src, 0);

    // Vector table: rr sweep, 3-beat lock, stall, lock with gaps
    setv( 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    setv( 1, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
    setv( 2, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1);
    setv( 3, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 1);
    setv( 4, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 1);
    setv( 5, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1);
    setv( 6, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    setv( 7, 4'b0111, 4'b0101, 1, 4'b0010, 0, 0, 0);
    setv( 8, 4'b0111, 4'b0101, 1, 4'b0010, 1, 1, 0);
    setv( 9, 4'b0111, 4'b0111, 1, 4'b0010, 1, 1, 0);
    setv(10, 4'b0101, 4'b0101, 1, 4'b0100, 1, 1, 1);
    setv(11, 4'b0001, 4'b0001, 1, 4'b0001, 1, 2, 1);
    setv(12, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1);
    setv(13, 4'b0110, 4'b0110, 1, 4'b0010, 0, 0, 0);
    setv(14, 4'b0100, 4'b0100, 0, 4'b0000, 1, 1, 1);
    setv(15, 4'b0100, 4'b0100, 0, 4'b0000, 1, 1, 1);
    setv(16, 4'b0100, 4'b0100, 0, 4'b0000, 1, 1, 1);
    setv(17, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 1);
    setv(18, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 1);
    setv(19, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    setv(20, 4'b1000, 4'b0000, 1, 4'b1000, 0, 0, 0);
    setv(21, 4'b0001, 4'b0001, 1, 4'b1000, 1, 3, 0);
    setv(22, 4'b0001, 4'b0001, 1, 4'b1000, 0, 0, 0);
    setv(23, 4'b1001, 4'b1001, 1, 4'b1000, 0, 0, 0);
    setv(24, 4'b0001, 4'b0001, 1, 4'b0001, 1, 3, 1);
    setv(25, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1);
    setv(26, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

    do_reset();
    for (int r = 0; r < 27; r++) begin
      @(posedge clk); #1;
      bus.in_valid  = vecs[r].valid;
      bus.in_last   = vecs[r].last;
      bus.out_allow = vecs[r].allow;
      @(negedge clk);
      $display("row %0d valid=%b last=%b allow=%b allowin=%b ov=%b src=%0d data=%h olast=%b",
               r, vecs[r].valid, vecs[r].last, vecs[r].allow, bus.in_allowin,
               bus.out_valid, bus.out_src, bus.out_data, bus.out_last);
      chk($sformatf("row%0d_allowin", r), bus.in_allowin, vecs[r].exp_allowin);
      chk($sformatf("row%0d_out_valid", r), bus.out_valid, vecs[r].exp_ov);
      if (vecs[r].exp_ov) begin
        chk($sformatf("row%0d_out_src", r), bus.out_src, vecs[r].exp_src);
        chk($sformatf("row%0d_out_last", r), bus.out_last, vecs[r].exp_olast);
        chk($sformatf("row%0d_out_data", r), bus.out_data, 4'hA + {2'b00, vecs[r].exp_src});
      end
    end

    // Randomized traffic with per-source scoreboard
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; open_pkt[i] = 1'b0; acc[i] = 1'b0;
      cur_last[i] = 1'b1; cur_data[i] = '0; seq[i] = '0;
    end
    owner = '0;
    owner_active = 1'b0;
    for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
    k = 0;
    while (!sb_idle() && k < 400) begin
      rand_cycle(1'b1);
      k++;
    end
    chk("drain_within_bound", 32'(sb_idle()), 32'd1);
    for (int i = 0; i < N; i++) chk($sformatf("sb_empty_src%0d", i), sbq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
